vcxo_lock_monitor: RTL

//  Consumes the measurement results of the VCXO frequency controller (signed freq error + PWM word per gate period).

---
 rtl/vcxo_lock_monitor_pkg.sv | 34 +++
 rtl/vcxo_lock_monitor_if.sv | 34 +++
 rtl/vcxo_err_tracker.sv | 40 ++++
 rtl/vcxo_lock_monitor.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/vcxo_lock_monitor_pkg.sv
// Shared types and defaults for the VCXO lock monitor.
// Lock FSM encoding and the 24/16-bit datapath widths.
package vcxo_lock_monitor_pkg;

    localparam int ERR_W = 24;
    localparam int CNT_W = 16;

    localparam int DEF_LOCK_WINDOW    = 4;
    localparam int DEF_LOCK_COUNT     = 8;
    localparam int DEF_UNLOCK_COUNT   = 3;
    localparam int DEF_PWM_MAX        = 122880;
    localparam int DEF_RAIL_MARGIN    = 1000;
    localparam int DEF_TIMEOUT_CYCLES = 368640;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    typedef logic signed [ERR_W-1:0] err_t;
    typedef logic [CNT_W-1:0]        cnt_t;

    // One extra bit so that -2^23 yields +2^23 instead of wrapping.
    function automatic logic [ERR_W:0] abs_err(err_t e);
        logic signed [ERR_W:0] x;
        logic [ERR_W:0]        r;
        x = {e[ERR_W-1], e};
        r = x[ERR_W] ? -x : x;
        return r;
    endfunction

endpackage

// File: rtl/vcxo_lock_monitor_if.sv
// Measurement, status and snapshot signals of the lock monitor.
// master = controller/MCU side, slave = monitor.
interface vcxo_lock_monitor_if;
    import vcxo_lock_monitor_pkg::*;

    logic       meas_valid;
    err_t       freq_error;
    err_t       pwm;
    logic       locked;
    logic       rail_alarm;
    logic       timeout_alarm;
    logic       snap_req;
    logic       snap_ack;
    err_t       snap_err_min;
    err_t       snap_err_max;
    err_t       snap_pwm;
    cnt_t       snap_meas_cnt;
    logic [3:0] snap_status;

    modport master (
        output meas_valid, freq_error, pwm, snap_req,
        input  locked, rail_alarm, timeout_alarm, snap_ack,
        input  snap_err_min, snap_err_max, snap_pwm,
        input  snap_meas_cnt, snap_status
    );

    modport slave (
        input  meas_valid, freq_error, pwm, snap_req,
        output locked, rail_alarm, timeout_alarm, snap_ack,
        output snap_err_min, snap_err_max, snap_pwm,
        output snap_meas_cnt, snap_status
    );

endinterface

// File: rtl/vcxo_err_tracker.sv
// Signed min/max of freq_error plus a saturating sample count.
// clear restarts tracking; a sample on the clear edge seeds it.
module vcxo_err_tracker
    import vcxo_lock_monitor_pkg::*;
(
    input  logic clk_in,
    input  logic reset_in,
    input  logic sample,
    input  logic clear,
    input  err_t err,
    output err_t err_min,
    output err_t err_max,
    output cnt_t cnt
);

    logic seeded;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            seeded  <= 1'b0;
            err_min <= '0;
            err_max <= '0;
            cnt     <= '0;
        end else if (clear) begin
            seeded  <= sample;
            err_min <= sample ? err : '0;
            err_max <= sample ? err : '0;
            cnt     <= sample ? cnt_t'(1) : '0;
        end else if (sample) begin
            seeded <= 1'b1;
            if (!seeded || err < err_min)
                err_min <= err;
            if (!seeded || err > err_max)
                err_max <= err;
            if (cnt != '1)
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vcxo_lock_monitor.sv
// VCXO loop lock qualifier with rail/timeout alarms and a
// req/ack status snapshot for the MCU register side.
module vcxo_lock_monitor
    import vcxo_lock_monitor_pkg::*;
#(
    parameter int LOCK_WINDOW    = DEF_LOCK_WINDOW,
    parameter int LOCK_COUNT     = DEF_LOCK_COUNT,
    parameter int UNLOCK_COUNT   = DEF_UNLOCK_COUNT,
    parameter int PWM_MAX        = DEF_PWM_MAX,
    parameter int RAIL_MARGIN    = DEF_RAIL_MARGIN,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input logic                clk_in,
    input logic                reset_in,
    vcxo_lock_monitor_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam err_t RAIL_LO = err_t'(RAIL_MARGIN);
    localparam err_t RAIL_HI = err_t'(PWM_MAX - RAIL_MARGIN);
    localparam logic [ERR_W:0] WIN = (ERR_W+1)'(LOCK_WINDOW);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] IN_LAST = 8'(LOCK_COUNT - 1);
    localparam logic [7:0] OUT_LAST = 8'(UNLOCK_COUNT - 1);

    state_t          state;
    logic [7:0]      in_cnt;
    logic [7:0]      out_cnt;
    logic [TW-1:0]   idle_cnt;
    logic            locked_r;
    logic            rail_r;
    logic            timeout_r;
    err_t            last_pwm;
    err_t            trk_min;
    err_t            trk_max;
    cnt_t            trk_cnt;

    logic in_win;
    logic railed;
    logic good;
    logic bad;
    logic capture;

    assign in_win  = abs_err(bus.freq_error) <= WIN;
    assign railed  = (bus.pwm <= RAIL_LO) || (bus.pwm >= RAIL_HI);
    assign good    = in_win && !railed;
    assign bad     = !in_win || railed;
    assign capture = bus.snap_req && !bus.snap_ack;

    assign bus.locked        = locked_r;
    assign bus.rail_alarm    = rail_r;
    assign bus.timeout_alarm = timeout_r;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state     <= ST_IDLE;
            in_cnt    <= '0;
            out_cnt   <= '0;
            idle_cnt  <= '0;
            locked_r  <= 1'b0;
            rail_r    <= 1'b0;
            timeout_r <= 1'b0;
            last_pwm  <= '0;
        end else if (bus.meas_valid) begin
            idle_cnt  <= '0;
            rail_r    <= railed;
            timeout_r <= 1'b0;
            last_pwm  <= bus.pwm;
            unique case (state)
                ST_LOCKED: begin
                    if (!bad) begin
                        out_cnt <= '0;
                    end else if (out_cnt == OUT_LAST) begin
                        state    <= ST_ACQUIRE;
                        locked_r <= 1'b0;
                        out_cnt  <= '0;
                    end else begin
                        out_cnt <= out_cnt + 1'b1;
                    end
                end
                ST_IDLE, ST_ACQUIRE, ST_TIMEOUT: begin
                    state <= ST_ACQUIRE;
                    if (!good) begin
                        in_cnt <= '0;
                    end else if (in_cnt == IN_LAST) begin
                        state    <= ST_LOCKED;
                        locked_r <= 1'b1;
                        in_cnt   <= '0;
                    end else begin
                        in_cnt <= in_cnt + 1'b1;
                    end
                end
            endcase
        end else begin
            if (idle_cnt != T_MAX)
                idle_cnt <= idle_cnt + 1'b1;
            // IDLE never times out; TIMEOUT waits for a measurement.
            if ((state == ST_ACQUIRE || state == ST_LOCKED) &&
                idle_cnt == T_LAST) begin
                state     <= ST_TIMEOUT;
                locked_r  <= 1'b0;
                timeout_r <= 1'b1;
                in_cnt    <= '0;
                out_cnt   <= '0;
            end
        end
    end

    vcxo_err_tracker u_trk (
        .clk_in  (clk_in),
        .reset_in(reset_in),
        .sample  (bus.meas_valid),
        .clear   (capture),
        .err     (bus.freq_error),
        .err_min (trk_min),
        .err_max (trk_max),
        .cnt     (trk_cnt)
    );

    // Snapshot takes pre-update values, so a coincident sample
    // lands only in the freshly cleared trackers.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            bus.snap_ack      <= 1'b0;
            bus.snap_err_min  <= '0;
            bus.snap_err_max  <= '0;
            bus.snap_pwm      <= '0;
            bus.snap_meas_cnt <= '0;
            bus.snap_status   <= '0;
        end else begin
            bus.snap_ack <= bus.snap_req;
            if (capture) begin
                bus.snap_err_min  <= trk_min;
                bus.snap_err_max  <= trk_max;
                bus.snap_pwm      <= last_pwm;
                bus.snap_meas_cnt <= trk_cnt;
                bus.snap_status   <= {state, rail_r, timeout_r};
            end
        end
    end

endmodule
